// File: rtl/register_file_if.sv
// register_file_if: write-back, decode-read, debug and status signals of the register file
interface register_file_if;
   logic        RegwriteW;
   logic [2:0]  RdW;
   logic [15:0] ResultW;
   logic [2:0]  Rs1D;
   logic [2:0]  Rs2D;
   logic [15:0] RD1D;
   logic [15:0] RD2D;
   logic [2:0]  DbgSel;
   logic [15:0] DbgData;
   logic [7:0]  ValidMask;
   logic [15:0] WrCount;
   modport master (
      output RegwriteW, RdW, ResultW, Rs1D, Rs2D, DbgSel,
      input  RD1D, RD2D, DbgData, ValidMask, WrCount
   );
   modport slave (
      input  RegwriteW, RdW, ResultW, Rs1D, Rs2D, DbgSel,
      output RD1D, RD2D, DbgData, ValidMask, WrCount
   );
endinterface

// File: rtl/register_file.sv
// register_file: 8x16 register file, R0 hardwired to zero, write-back bypass, valid mask and write counter
module register_file (
   input logic clk,
   input logic rst,
   register_file_if.slave rf
);
   logic [7:0][15:0] regs_q, regs_d;
   logic [7:0]       valid_q, valid_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             we;
   always_comb begin
      we = rf.RegwriteW && (rf.RdW != 3'd0);
      regs_d = regs_q;
      valid_d = valid_q;
      if (we) begin
         regs_d[rf.RdW] = rf.ResultW;
         valid_d[rf.RdW] = 1'b1;
      end
      regs_d[0] = 16'h0000;
      valid_d[0] = 1'b0;
      cnt_d = cnt_q + {15'd0, we && (cnt_q != 16'hFFFF)};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '0;
         valid_q <= '0;
         cnt_q <= '0;
      end else begin
         regs_q <= regs_d;
         valid_q <= valid_d;
         cnt_q <= cnt_d;
      end
   end
   // bypass is gated by rst so reads stay zero throughout reset
   assign rf.RD1D = (we && !rst && rf.Rs1D == rf.RdW) ? rf.ResultW : regs_q[rf.Rs1D];
   assign rf.RD2D = (we && !rst && rf.Rs2D == rf.RdW) ? rf.ResultW : regs_q[rf.Rs2D];
   assign rf.DbgData = regs_q[rf.DbgSel];
   assign rf.ValidMask = valid_q;
   assign rf.WrCount = cnt_q;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench with a behavioural register-file model and randomized traffic
module tb_register_file;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   register_file_if rf ();
   register_file dut (.clk(clk), .rst(rst), .rf(rf.slave));
   typedef struct {
      string       n;
      logic [15:0] rd1, rd2, dbg, wc;
      logic [7:0]  vm;
   } exp_t;
   exp_t q[$];
   int asserts = 0;
   int fails = 0;
   logic [15:0] m [8];
   logic [7:0]  vm;
   logic [15:0] wc;
   task automatic chk(input string n, input string f, input logic [15:0] a, input logic [15:0] e);
      asserts++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s.%s got %h expected %h", n, f, a, e);
      end
   endtask
   // monitor: outputs are sampled mid-cycle, away from the rising edge
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.n, "RD1D", rf.RD1D, e.rd1);
         chk(e.n, "RD2D", rf.RD2D, e.rd2);
         chk(e.n, "DbgData", rf.DbgData, e.dbg);
         chk(e.n, "ValidMask", {8'h00, rf.ValidMask}, {8'h00, e.vm});
         chk(e.n, "WrCount", rf.WrCount, e.wc);
      end
   end
   task automatic model_reset();
      for (int i = 0; i < 8; i++) m[i] = 16'h0000;
      vm = 8'h00;
      wc = 16'h0000;
   endtask
   task automatic drive(input bit we, input bit [2:0] rd, input bit [15:0] res,
                        input bit [2:0] s1, input bit [2:0] s2, input bit [2:0] ds, input string n);
      exp_t e;
      bit   fwd;
      rf.RegwriteW = we;
      rf.RdW = rd;
      rf.ResultW = res;
      rf.Rs1D = s1;
      rf.Rs2D = s2;
      rf.DbgSel = ds;
      fwd = we && rd != 3'd0 && !rst;
      e.n = n;
      e.rd1 = (fwd && s1 == rd) ? res : m[s1];
      e.rd2 = (fwd && s2 == rd) ? res : m[s2];
      e.dbg = m[ds];
      e.vm = vm;
      e.wc = wc;
      q.push_back(e);
      @(posedge clk);
      if (we && rd != 3'd0 && !rst) begin
         m[rd] = res;
         vm[rd] = 1'b1;
         if (wc != 16'hFFFF) wc = wc + 16'd1;
      end
      #1;
   endtask
   initial begin
      model_reset();
      rf.RegwriteW = 1'b0;
      rf.RdW = 3'd0;
      rf.ResultW = 16'h0000;
      rf.Rs1D = 3'd0;
      rf.Rs2D = 3'd0;
      rf.DbgSel = 3'd0;
      @(posedge clk);
      #1;
      drive(1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 3'd7, "reset_read");
      drive(1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 3'd3, "reset_no_bypass");
      rst = 1'b0;
      drive(1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 3'd7, "post_reset");
      drive(1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd0, 3'd3, "bypass_r3");
      drive(1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 3'd3, "dbg_r3");
      drive(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 3'd0, "write_r0");
      drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, 3'd0, "r0_after");
      drive(1'b1, 3'd2, 16'h1111, 3'd2, 3'd2, 3'd2, "r2_first");
      drive(1'b1, 3'd2, 16'h2222, 3'd2, 3'd2, 3'd2, "r2_second");
      drive(1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 3'd2, "r2_final");
      for (int i = 0; i < 300; i++)
         drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "random");
      drive(1'b1, 3'd4, 16'h1234, 3'd4, 3'd1, 3'd4, "r4_write");
      drive(1'b0, 3'd0, 16'h0000, 3'd4, 3'd1, 3'd4, "r4_read");
      rst = 1'b1;
      model_reset();
      drive(1'b0, 3'd0, 16'h0000, 3'd4, 3'd1, 3'd4, "async_rst");
      drive(1'b1, 3'd4, 16'h5555, 3'd4, 3'd4, 3'd4, "write_in_rst");
      rst = 1'b0;
      drive(1'b0, 3'd0, 16'h0000, 3'd4, 3'd4, 3'd4, "after_rst");
      for (int i = 0; i < 65534 + 3; i++)
         drive(1'b1, 3'd1, 16'(i), 3'd1, 3'd2, 3'd1, "saturate");
      drive(1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, 3'd1, "sat_hold");
      drive(1'b1, 3'd6, 16'h6666, 3'd6, 3'd1, 3'd6, "sat_write");
      drive(1'b0, 3'd0, 16'h0000, 3'd6, 3'd1, 3'd6, "sat_final");
      for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain %0d entries left, 0 required", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port RegwriteW, input, 1, write-back write enable.
REQ-004 SHALL have port RdW, input, 3, write-back destination register index.
REQ-005 SHALL have port ResultW, input, 16, write-back data.
REQ-006 SHALL have ports Rs1D and Rs2D, input, 3 each, decode-stage source indices.
REQ-007 SHALL have ports RD1D and RD2D, output, 16 each, decode-stage read data.
REQ-008 SHALL have port DbgSel, input, 3, debug read index.
REQ-009 SHALL have port DbgData, output, 16, debug read data (no bypass).
REQ-010 SHALL have port ValidMask, output, 8, bit i set when register i has been written since reset.
REQ-011 SHALL have port WrCount, output, 16, count of committed writes since reset.

Function
REQ-012 SHALL hold eight 16-bit registers R0..R7.
REQ-013 SHALL hardwire R0 to zero; reads of index 0 return 0x0000 on every port.
REQ-014 SHALL commit a write of ResultW to R[RdW] on the rising edge when RegwriteW=1 and RdW!=0.
REQ-015 SHALL ignore writes with RdW=0; no storage, ValidMask or WrCount change.
REQ-016 SHALL return RD1D/RD2D combinationally from storage, zero latency.
REQ-017 SHALL bypass: when RegwriteW=1, RdW!=0 and RsxD==RdW, RDxD SHALL equal ResultW in the same cycle.
REQ-018 SHALL apply bypass independently per port; Rs1D==Rs2D==RdW drives ResultW on both.
REQ-019 SHALL return DbgData from storage only; the written value appears the cycle after the commit edge.
REQ-020 SHALL set ValidMask[RdW] on each committed write; bits never clear except by reset; ValidMask[0] is constant 0.
REQ-021 SHALL increment WrCount by 1 per committed write and saturate at 0xFFFF.
REQ-022 SHALL update ValidMask and WrCount on the same edge as the storage write.
REQ-023 SHALL, on back-to-back writes to the same register, keep the last value; each write increments WrCount.
REQ-024 SHALL treat X-free inputs only; behaviour with unknown RdW while RegwriteW=1 is undefined.

Reset
REQ-025 SHALL, while rst=1, clear R1..R7 to 0x0000, ValidMask to 0x00 and WrCount to 0x0000, independent of clk.
REQ-026 SHALL, while rst=1, ignore RegwriteW; RD1D/RD2D/DbgData read 0x0000 except via bypass, which SHALL be suppressed during reset.
REQ-027 SHALL resume normal writes on the first rising edge after rst deasserts.
REQ-028 SHALL abort an in-progress write whose edge coincides with rst=1; no state changes.

Verification
REQ-029 Reset then Rs1D=3, Rs2D=5, DbgSel=7 -> RD1D=RD2D=DbgData=0x0000, ValidMask=0x00, WrCount=0.
REQ-030 RegwriteW=1, RdW=3, ResultW=0xA5A5, Rs1D=3 -> RD1D=0xA5A5 same cycle (bypass); DbgSel=3 reads 0xA5A5 next cycle; ValidMask=0x08, WrCount=1.
REQ-031 RegwriteW=1, RdW=0, ResultW=0xFFFF -> RD1D with Rs1D=0 reads 0x0000; ValidMask and WrCount unchanged.
REQ-032 Write R2=0x1111 then R2=0x2222 on consecutive edges, Rs1D=Rs2D=2 -> both ports read 0x2222 after second edge; WrCount=2; ValidMask=0x04.
REQ-033 Preload WrCount to 0xFFFE via 0xFFFE writes to R1, then 3 more writes -> WrCount=0xFFFF and holds.
REQ-034 Write R4=0x1234, then assert rst mid-cycle asynchronously -> R4, ValidMask, WrCount read 0 immediately without a clock edge.
